bf_prog_loader: RTL and testbench

UART program loader for the TinyBF CPU; it is the initiator that drives the bf_top program upload port (prog_we_i / prog_waddr_i / prog_wdata_i). It receives serial 8N1 bytes on its own RX pin and parses a framed packet (sync, length, data, XOR checksum). Each data byte is written into program memory as it arrives, and the packet result is reported on done/error flags. The board wrapper instantiates it beside bf_top and gates it with the CPU's busy status.

---
 rtl/bf_prog_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_bf_prog_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bf_prog_loader
//  Purpose  : UART program loader for the TinyBF CPU. Receives 8N1 serial
//             bytes, parses a framed packet (0xA5 sync, length N, N data
//             bytes, XOR checksum) and writes each data byte straight into
//             program memory as it arrives.
//  Ports    :
//    clk_i         system clock, rising edge
//    rst_i         asynchronous active-low reset
//    uart_rx_i     serial input, idle high, 8N1 LSB first (asynchronous)
//    enable_i      loader permitted (tied to !cpu_busy on the board)
//    prog_we_o     one-cycle program memory write strobe
//    prog_waddr_o  write address (holds until the next write)
//    prog_wdata_o  write data (holds until the next write)
//    load_busy_o   high from accepted sync byte until packet end/abort
//    load_done_o   one-cycle pulse on a packet with a good checksum
//    load_err_o    sticky error, cleared by the next accepted sync byte
//  Revision : 1.0 - initial release
// ============================================================================
module bf_prog_loader #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 38400,
  parameter int ADDR_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              uart_rx_i,
  input  logic              enable_i,
  output logic              prog_we_o,
  output logic [ADDR_W-1:0] prog_waddr_o,
  output logic [7:0]        prog_wdata_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int TW   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0] c_div_m1  = TW'(DIV - 1);
  localparam logic [TW-1:0] c_half_m1 = TW'(HALF - 1);
  localparam logic [7:0]    c_sync    = 8'hA5;
  localparam logic [8:0]    c_max_len = 9'(1 << ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_LEN, P_DATA, P_CSUM} pkt_state_t;

  // --------------------------------------------------------------------------
  // Input synchronizer (resets to the idle-high line level)
  // --------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Byte receiver
  // --------------------------------------------------------------------------
  rx_state_t      rx_state_q, rx_state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           brk_q, brk_d;          // low stop bit seen, waiting for idle line
  logic           byte_vld_q, byte_vld_d;
  logic           frame_err_q, frame_err_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_state_q  <= RX_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      brk_q       <= 1'b0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      brk_q       <= brk_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    timer_d     = timer_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    brk_d       = brk_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid start bit: a line back high means the falling edge was a glitch.
        if (timer_q == c_half_m1) begin
          timer_d   = '0;
          bit_idx_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer_q == c_div_m1) begin
          timer_d = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (brk_q) begin
          // Stay here until the line is released, so a held-low break
          // is not mistaken for a fresh start bit.
          timer_d = '0;
          if (rx_sync_q) begin
            brk_d      = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (timer_q == c_div_m1) begin
          timer_d = '0;
          if (rx_sync_q) begin
            byte_vld_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Packet parser and program memory write port
  // --------------------------------------------------------------------------
  pkt_state_t        pkt_state_q, pkt_state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] len_m1_q, len_m1_d;   // N-1, index of the last data byte
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pkt_state_q <= P_IDLE;
      cnt_q       <= '0;
      len_m1_q    <= '0;
      csum_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pkt_state_q <= pkt_state_d;
      cnt_q       <= cnt_d;
      len_m1_q    <= len_m1_d;
      csum_q      <= csum_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    pkt_state_d = pkt_state_q;
    cnt_d       = cnt_q;
    len_m1_d    = len_m1_q;
    csum_d      = csum_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    if (pkt_state_q == P_IDLE) begin
      if (byte_vld_q && enable_i && (shift_q == c_sync)) begin
        busy_d      = 1'b1;
        err_d       = 1'b0;
        pkt_state_d = P_LEN;
      end
    end else if (!enable_i || frame_err_q) begin
      // Abort mid-packet; writes already issued stay in memory.
      err_d       = 1'b1;
      busy_d      = 1'b0;
      pkt_state_d = P_IDLE;
    end else if (byte_vld_q) begin
      unique case (pkt_state_q)
        P_LEN: begin
          if ((shift_q == 8'd0) || ({1'b0, shift_q} > c_max_len)) begin
            err_d       = 1'b1;
            busy_d      = 1'b0;
            pkt_state_d = P_IDLE;
          end else begin
            cnt_d       = '0;
            len_m1_d    = ADDR_W'(shift_q - 8'd1);
            csum_d      = shift_q;
            pkt_state_d = P_DATA;
          end
        end
        P_DATA: begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = shift_q;
          csum_d  = csum_q ^ shift_q;
          if (cnt_q == len_m1_q) pkt_state_d = P_CSUM;
          else                   cnt_d       = cnt_q + 1'b1;
        end
        P_CSUM: begin
          if (shift_q == csum_q) done_d = 1'b1;
          else                   err_d  = 1'b1;
          busy_d      = 1'b0;
          pkt_state_d = P_IDLE;
        end
        default: pkt_state_d = P_IDLE;
      endcase
    end
  end

  assign prog_we_o    = we_q;
  assign prog_waddr_o = waddr_q;
  assign prog_wdata_o = wdata_q;
  assign load_busy_o  = busy_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bf_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bf_prog_loader
//  Purpose  : Self-checking bench for bf_prog_loader. Serial bytes are
//             driven onto the RX pin; a packet-level reference model derives
//             the expected program writes, done pulses and error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bf_prog_loader;

  localparam int CLK_FREQ  = 160;
  localparam int BAUD_RATE = 10;
  localparam int ADDR_W    = 4;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx = 1'b1;
  logic              en = 1'b1;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_waddr;
  logic [7:0]        prog_wdata;
  logic              load_busy, load_done, load_err;

  always #5 clk = ~clk;

  bf_prog_loader #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .ADDR_W   (ADDR_W)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .uart_rx_i   (rx),
    .enable_i    (en),
    .prog_we_o   (prog_we),
    .prog_waddr_o(prog_waddr),
    .prog_wdata_o(prog_wdata),
    .load_busy_o (load_busy),
    .load_done_o (load_done),
    .load_err_o  (load_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write / done observer
  logic [11:0] obs[$];
  int          done_cnt = 0;
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (prog_we) begin
      chk("we_single_cycle", 32'(prev_we), 32'd0);
      obs.push_back({prog_waddr, prog_wdata});
    end
    if (load_done) begin
      chk("done_single_cycle", 32'(prev_done), 32'd0);
      done_cnt++;
    end
    prev_we   = prog_we;
    prev_done = load_done;
  end

  // Reference model: walks a byte stream with the packet rules
  logic [7:0]  stim[$];
  logic [11:0] exp_w[$];
  int          exp_done;
  logic        exp_err = 1'b0;

  task automatic model_run();
    int i;
    int n;
    logic [7:0] cs;
    exp_w.delete();
    exp_done = 0;
    i = 0;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin
        i++;
      end else begin
        exp_err = 1'b0;
        i++;
        if (i >= stim.size()) break;
        n = int'(stim[i]);
        i++;
        if (n == 0 || n > (1 << ADDR_W)) begin
          exp_err = 1'b1;
        end else begin
          cs = 8'(n);
          for (int k = 0; k < n && i < stim.size(); k++) begin
            exp_w.push_back({4'(k), stim[i]});
            cs = cs ^ stim[i];
            i++;
          end
          if (i < stim.size()) begin
            if (stim[i] == cs) exp_done++;
            else               exp_err = 1'b1;
            i++;
          end
        end
      end
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
    if (!stop_v) send_bit(1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_stream(input string nm, input bit busy_mid);
    model_run();
    obs.delete();
    done_cnt = 0;
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], 1'b1);
      if (busy_mid && i == 0) begin
        chk({nm, "_busy_after_sync"}, 32'(load_busy), 32'd1);
        chk({nm, "_err_cleared"}, 32'(load_err), 32'd0);
      end
      if (busy_mid && i == stim.size() - 2)
        chk({nm, "_busy_before_csum"}, 32'(load_busy), 32'd1);
    end
    repeat (20) @(negedge clk);
    chk({nm, "_nwrites"}, 32'(obs.size()), 32'(exp_w.size()));
    for (int k = 0; k < obs.size() && k < exp_w.size(); k++)
      chk({nm, "_write"}, 32'(obs[k]), 32'(exp_w[k]));
    chk({nm, "_done"}, 32'(done_cnt), 32'(exp_done));
    chk({nm, "_err"}, 32'(load_err), 32'(exp_err));
    chk({nm, "_busy_end"}, 32'(load_busy), 32'd0);
    stim.delete();
  endtask

  task automatic push_good(input int n);
    logic [7:0] cs;
    logic [7:0] d;
    cs = 8'(n);
    stim.push_back(8'hA5);
    stim.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom_range(0, 255));
      stim.push_back(d);
      cs = cs ^ d;
    end
    stim.push_back(cs);
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_we"}, 32'(prog_we), 32'd0);
    chk({nm, "_waddr"}, 32'(prog_waddr), 32'd0);
    chk({nm, "_wdata"}, 32'(prog_wdata), 32'd0);
    chk({nm, "_busy"}, 32'(load_busy), 32'd0);
    chk({nm, "_done"}, 32'(load_done), 32'd0);
    chk({nm, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int n;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Good packet
    stim = '{8'hA5, 8'h03, 8'h2B, 8'h2E, 8'h5B, 8'h5D};
    run_stream("good", 1'b1);

    // Bad checksum, then recovery
    stim = '{8'hA5, 8'h02, 8'h2B, 8'h2D, 8'hFF};
    run_stream("badcs", 1'b1);
    stim = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    run_stream("recover", 1'b1);

    // Length bounds
    stim = '{8'hA5, 8'h00};
    run_stream("len0", 1'b0);
    stim = '{8'hA5, 8'h11};
    run_stream("len17", 1'b0);
    push_good(16);
    run_stream("len16", 1'b1);

    // Noise bytes and a short glitch
    stim = '{8'h00, 8'hFF, 8'h5A};
    run_stream("noise", 1'b0);
    obs.delete();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_nwrites", 32'(obs.size()), 32'd0);
    chk("glitch_busy", 32'(load_busy), 32'd0);
    push_good(3);
    run_stream("after_glitch", 1'b1);

    // Framing error on the second data byte
    obs.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (10) @(negedge clk);
    chk("frame_err", 32'(load_err), 32'd1);
    chk("frame_busy", 32'(load_busy), 32'd0);
    send_byte(8'h33, 1'b1);
    chk("frame_nwrites", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) chk("frame_write", 32'(obs[0]), 32'h011);
    exp_err = 1'b1;
    push_good(2);
    run_stream("after_frame", 1'b1);

    // Enable dropped mid-packet
    obs.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("endrop_err", 32'(load_err), 32'd1);
    chk("endrop_busy", 32'(load_busy), 32'd0);
    send_byte(8'h03, 1'b1);
    send_byte(8'hA5, 1'b1);
    chk("endis_sync_ignored", 32'(load_busy), 32'd0);
    en = 1'b1;
    send_byte(8'h03, 1'b1);
    chk("endrop_nwrites", 32'(obs.size()), 32'd2);
    exp_err = 1'b1;

    // Reset during the second data byte
    obs.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset_nwrites", 32'(obs.size()), 32'd1);
    exp_err = 1'b0;
    push_good(5);
    run_stream("after_reset", 1'b1);

    // Randomized packets with noise, bad lengths and corrupted checksums
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        v = 8'($urandom_range(0, 255));
        if (v == 8'hA5) v = 8'h3C;
        stim.push_back(v);
      end
      if ($urandom_range(0, 5) == 0) begin
        stim.push_back(8'hA5);
        stim.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        n = int'($urandom_range(1, 16));
        push_good(n);
        if ($urandom_range(0, 2) == 0)
          stim[stim.size() - 1] = stim[stim.size() - 1] ^ 8'($urandom_range(1, 255));
      end
      run_stream("random", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
